spi_responder: RTL and testbench

//  SPI mode-0 target: the responder end of our 16-bit SPI master frame.

---
 rtl/spi_responder.sv | 189 ++++++++++++++++++
 tb/tb_spi_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_responder.sv
// SPI mode-0 responder: receives an 8-bit command then an 8-bit data byte,
// returning a response byte on MISO during the data phase.
module spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_cs,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    input  logic [7:0] rsp_data,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        CMD       = 2'd2,
        DATA      = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   cs_prev;

    logic sclk_last;
    logic cs_last;
    logic mosi_last;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    state_t     state_q,      state_n;
    logic [4:0] bit_cnt_q,    bit_cnt_n;
    logic [6:0] cmd_shift_q,  cmd_shift_n;
    logic [7:0] data_shift_q, data_shift_n;
    logic [6:0] rsp_shift_q,  rsp_shift_n;
    logic       miso_q,       miso_n;
    logic       cmd_valid_q,  cmd_valid_n;
    logic [7:0] cmd_byte_q,   cmd_byte_n;
    logic       rx_valid_q,   rx_valid_n;
    logic [7:0] rx_data_q,    rx_data_n;
    logic       frame_err_q,  frame_err_n;
    logic       busy_n;

    assign sclk_last = sclk_sync[SYNC_STAGES-1];
    assign cs_last   = cs_sync[SYNC_STAGES-1];
    assign mosi_last = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_last  & ~sclk_prev;
    assign sclk_fall = ~sclk_last & sclk_prev;
    assign cs_rise   = cs_last    & ~cs_prev;
    assign cs_fall   = ~cs_last   & cs_prev;

    // State and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync    <= '0;
            cs_sync      <= '0;
            mosi_sync    <= '0;
            sclk_prev    <= 1'b0;
            cs_prev      <= 1'b0;
            state_q      <= WAIT_IDLE;
            bit_cnt_q    <= 5'd0;
            cmd_shift_q  <= 7'd0;
            data_shift_q <= 8'd0;
            rsp_shift_q  <= 7'd0;
            miso_q       <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= 8'd0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= 8'd0;
            frame_err_q  <= 1'b0;
        end else begin
            sclk_sync    <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            cs_sync      <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            mosi_sync    <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev    <= sclk_last;
            cs_prev      <= cs_last;
            state_q      <= state_n;
            bit_cnt_q    <= bit_cnt_n;
            cmd_shift_q  <= cmd_shift_n;
            data_shift_q <= data_shift_n;
            rsp_shift_q  <= rsp_shift_n;
            miso_q       <= miso_n;
            cmd_valid_q  <= cmd_valid_n;
            cmd_byte_q   <= cmd_byte_n;
            rx_valid_q   <= rx_valid_n;
            rx_data_q    <= rx_data_n;
            frame_err_q  <= frame_err_n;
        end
    end

    // Next-state logic; CS deassertion always wins over a same-cycle SCLK edge.
    always_comb begin
        state_n = state_q;
        case (state_q)
            WAIT_IDLE: if (cs_last) state_n = IDLE;
            IDLE:      if (!cs_rise && cs_fall) state_n = CMD;
            CMD: begin
                if (cs_rise)
                    state_n = IDLE;
                else if (sclk_fall && bit_cnt_q == 5'd8)
                    state_n = DATA;
            end
            DATA:      if (cs_rise) state_n = IDLE;
            default:   state_n = WAIT_IDLE;
        endcase
    end

    // Datapath and output next values. cmd_valid, rx_valid and frame_err are
    // single-cycle strobes with no ready/backpressure: the consumer must
    // capture on the pulse; cmd_byte and rx_data hold until the next frame.
    always_comb begin
        bit_cnt_n    = bit_cnt_q;
        cmd_shift_n  = cmd_shift_q;
        data_shift_n = data_shift_q;
        rsp_shift_n  = rsp_shift_q;
        miso_n       = miso_q;
        cmd_valid_n  = 1'b0;
        cmd_byte_n   = cmd_byte_q;
        rx_valid_n   = 1'b0;
        rx_data_n    = rx_data_q;
        frame_err_n  = 1'b0;
        busy_n       = (state_q == CMD) || (state_q == DATA);

        if (state_q != WAIT_IDLE && cs_rise) begin
            if (bit_cnt_q == 5'd16) begin
                rx_valid_n = 1'b1;
                rx_data_n  = data_shift_q;
            end else begin
                frame_err_n = 1'b1;
            end
            miso_n = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    miso_n = 1'b0;
                    if (cs_fall) bit_cnt_n = 5'd0;
                end
                CMD: begin
                    if (sclk_rise && bit_cnt_q < 5'd8) begin
                        cmd_shift_n = {cmd_shift_q[5:0], mosi_last};
                        bit_cnt_n   = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            cmd_byte_n  = {cmd_shift_q, mosi_last};
                            cmd_valid_n = 1'b1;
                        end
                    end else if (sclk_fall && bit_cnt_q == 5'd8) begin
                        // Bit 7 goes straight to the pin; the shifter keeps the rest.
                        rsp_shift_n = rsp_data[6:0];
                        miso_n      = rsp_data[7];
                    end
                end
                DATA: begin
                    if (sclk_rise) begin
                        if (bit_cnt_q < 5'd16) begin
                            data_shift_n = {data_shift_q[6:0], mosi_last};
                            bit_cnt_n    = bit_cnt_q + 5'd1;
                        end else begin
                            bit_cnt_n = 5'd17;
                        end
                    end else if (sclk_fall && bit_cnt_q >= 5'd9 && bit_cnt_q <= 5'd15) begin
                        miso_n      = rsp_shift_q[6];
                        rsp_shift_n = {rsp_shift_q[5:0], 1'b0};
                    end
                end
                default: miso_n = 1'b0;
            endcase
        end
    end

    assign spi_miso  = miso_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_byte  = cmd_byte_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_n;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: a task-driven SPI master, a frame-level reference
// model feeding expected queues, and pulse monitors checked against them.
module tb_spi_responder;

    localparam int HALF = 6;
    localparam int GAP  = 8;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       spi_clk  = 1'b0;
    logic       spi_cs   = 1'b1;
    logic       spi_mosi = 1'b0;
    logic [7:0] rsp_data = 8'd0;
    logic       spi_miso;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       busy;

    spi_responder #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_clk   (spi_clk),
        .spi_cs    (spi_cs),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .cmd_valid (cmd_valid),
        .cmd_byte  (cmd_byte),
        .rsp_data  (rsp_data),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // Clock and reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard state
    logic [7:0] exp_q[$];
    logic [7:0] exp_cmd_q[$];
    logic [7:0] exp_rx_data  = 8'd0;
    logic [7:0] exp_cmd_byte = 8'd0;
    int exp_rx_cnt  = 0;
    int exp_cmd_cnt = 0;
    int exp_err_cnt = 0;
    int rx_cnt  = 0;
    int cmd_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse monitors
    always @(negedge clk) begin
        if (cmd_valid) begin
            cmd_cnt++;
            if (exp_cmd_q.size() != 0) check("cmd_byte_at_pulse", 32'(cmd_byte), 32'(exp_cmd_q.pop_front()));
        end
        if (rx_valid) begin
            rx_cnt++;
            if (exp_q.size() != 0) check("rx_data_at_pulse", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        if (frame_err) err_cnt++;
    end

    task automatic end_checks(input string tag);
        check({tag, "_cmd_cnt"}, 32'(cmd_cnt), 32'(exp_cmd_cnt));
        check({tag, "_rx_cnt"}, 32'(rx_cnt), 32'(exp_rx_cnt));
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err_cnt));
        check({tag, "_rx_data_hold"}, 32'(rx_data), 32'(exp_rx_data));
        check({tag, "_cmd_byte_hold"}, 32'(cmd_byte), 32'(exp_cmd_byte));
        check({tag, "_miso_idle"}, 32'(spi_miso), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    // Driver: one CS-low frame of nbits SCLK pulses; the master samples MISO
    // on rising edges 9..16 and compares against the response byte.
    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [7:0] data,
                             input int nbits, input logic [7:0] rsp, input logic [7:0] extra);
        logic [23:0] stream;
        logic [7:0]  got;
        stream = {cmd, data, extra};
        got    = 8'd0;
        if (nbits >= 8) begin
            exp_cmd_cnt++;
            exp_cmd_q.push_back(cmd);
            exp_cmd_byte = cmd;
        end
        if (nbits == 16) begin
            exp_rx_cnt++;
            exp_q.push_back(data);
            exp_rx_data = data;
        end else begin
            exp_err_cnt++;
        end
        rsp_data = rsp;
        spi_cs   = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = stream[23-i];
            wait_clks(HALF);
            spi_clk = 1'b1;
            if (i >= 8 && i < 16) got = {got[6:0], spi_miso};
            if (i == 0) check({tag, "_busy"}, 32'(busy), 32'd1);
            wait_clks(HALF);
            spi_clk = 1'b0;
        end
        wait_clks(HALF);
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        wait_clks(GAP);
        if (nbits >= 16) check({tag, "_miso_byte"}, 32'(got), 32'(rsp));
        end_checks(tag);
    endtask

    // Frame interrupted by reset after 5 bits; SCLK keeps running after release.
    task automatic run_reset_frame();
        spi_cs = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < 16; i++) begin
            spi_mosi = 1'($urandom_range(0, 1));
            wait_clks(HALF);
            spi_clk = 1'b1;
            wait_clks(HALF);
            spi_clk = 1'b0;
            if (i == 4) begin
                rst = 1'b0;
                wait_clks(3);
                check("rst_mid_cmd_valid", 32'(cmd_valid), 32'd0);
                check("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
                check("rst_mid_frame_err", 32'(frame_err), 32'd0);
                check("rst_mid_miso", 32'(spi_miso), 32'd0);
                check("rst_mid_busy", 32'(busy), 32'd0);
                check("rst_mid_rx_data", 32'(rx_data), 32'd0);
                check("rst_mid_cmd_byte", 32'(cmd_byte), 32'd0);
                exp_rx_data  = 8'd0;
                exp_cmd_byte = 8'd0;
                rst = 1'b1;
            end
        end
        wait_clks(HALF);
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        wait_clks(GAP);
        end_checks("rst_frame");
    endtask

    task automatic sclk_only(input int n);
        for (int i = 0; i < n; i++) begin
            spi_mosi = 1'($urandom_range(0, 1));
            wait_clks(HALF);
            spi_clk = 1'b1;
            check("cs_high_miso", 32'(spi_miso), 32'd0);
            wait_clks(HALF);
            spi_clk = 1'b0;
        end
        spi_mosi = 1'b0;
        wait_clks(GAP);
        end_checks("cs_high_sclk");
    endtask

    initial begin
        int nb;
        rst = 1'b0;
        wait_clks(5);
        check("reset_miso", 32'(spi_miso), 32'd0);
        check("reset_cmd_valid", 32'(cmd_valid), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_cmd_byte", 32'(cmd_byte), 32'd0);
        rst = 1'b1;
        wait_clks(GAP);

        run_frame("basic", 8'hA5, 8'h3C, 16, 8'h96, 8'h00);
        run_frame("b2b_a", 8'h01, 8'hFF, 16, 8'h00, 8'h00);
        run_frame("b2b_b", 8'h80, 8'h00, 16, 8'hFF, 8'h00);
        run_frame("pre_short", 8'h11, 8'h6B, 16, 8'h5A, 8'h00);
        run_frame("short12", 8'h5A, 8'hC3, 12, 8'h81, 8'h00);
        run_frame("after_short", 8'h22, 8'hD4, 16, 8'h3E, 8'h00);
        run_frame("long18", 8'h33, 8'h99, 18, 8'hC7, 8'hFF);
        run_frame("abort_cmd", 8'h44, 8'h00, 5, 8'h00, 8'h00);
        run_frame("exact8", 8'h77, 8'h00, 8, 8'h12, 8'h00);
        run_reset_frame();
        run_frame("post_rst", 8'hC8, 8'h4D, 16, 8'hE1, 8'h00);
        sclk_only(10);

        for (int k = 0; k < 30; k++) begin
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
            run_frame("rand", 8'($urandom), 8'($urandom), nb, 8'($urandom), 8'($urandom));
        end

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("exp_cmd_q_drained", 32'(exp_cmd_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
